// File: rtl/mdu_if.sv
// E-stage <-> MDU signal bundle: operation issue, operands, D-stage MDU use,
// and the busy/HI/LO/stall results returned to hazard logic and the result mux.
interface mdu_if;
  logic [2:0]  MDOPE;
  logic        startE;
  logic [31:0] AE;
  logic [31:0] BE;
  logic        MDUseD;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        stallMD;

  modport master (
    output MDOPE, startE, AE, BE, MDUseD,
    input  busy, HI, LO, stallMD
  );

  modport slave (
    input  MDOPE, startE, AE, BE, MDUseD,
    output busy, HI, LO, stallMD
  );
endinterface

// File: rtl/mdu_sched.sv
// MIPS multiply/divide scheduler: latches operands, runs a busy down-counter and
// commits HI/LO on completion. Define MDU_DIV_EN to build div/divu support.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset_n,
  mdu_if.slave   md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] CNT_IDLE  = 4'd0;
  localparam logic [3:0] CNT_LAST  = 4'd1;
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cycles
    $error("mdu_sched: MULT_CYCLES and DIV_CYCLES must be in 1..15");
  end

  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        idle;
  logic        is_mul_op;
  logic        is_div_op;
  logic        is_md_op;
  logic [3:0]  cnt_load;

  logic signed [63:0] mul_s;
  logic        [63:0] mul_u;
  logic        [31:0] res_hi;
  logic        [31:0] res_lo;
  logic               res_we;

  assign idle      = (cnt_q == CNT_IDLE);
  assign is_mul_op = (md.MDOPE == OP_MULT) || (md.MDOPE == OP_MULTU);

`ifdef MDU_DIV_EN
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  logic signed [31:0] sa, sb, sq, sr;
  logic        [31:0] b_safe, uq, ur;
  logic               div_ovf;

  assign is_div_op = (md.MDOPE == OP_DIV) || (md.MDOPE == OP_DIVU);
  assign cnt_load  = is_div_op ? DIV_LOAD : MULT_LOAD;

  // Divisor forced nonzero so the dividers never produce X; a zero divisor
  // suppresses the HI/LO write anyway.
  assign b_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
  assign sa      = a_q;
  assign sb      = b_safe;
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign sq      = div_ovf ? 32'sh8000_0000 : sa / sb;
  assign sr      = div_ovf ? 32'sd0 : sa % sb;
  assign uq      = a_q / b_safe;
  assign ur      = a_q % b_safe;
`else
  assign is_div_op = 1'b0;
  assign cnt_load  = MULT_LOAD;
`endif

  assign is_md_op = is_mul_op || is_div_op;

  assign mul_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign mul_u = {32'd0, a_q} * {32'd0, b_q};

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_hi = mul_s[63:32];
        res_lo = mul_s[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res_hi = mul_u[63:32];
        res_lo = mul_u[31:0];
        res_we = 1'b1;
      end
`ifdef MDU_DIV_EN
      OP_DIV: begin
        res_hi = sr;
        res_lo = sq;
        res_we = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res_hi = ur;
        res_lo = uq;
        res_we = (b_q != 32'd0);
      end
`endif
      default: res_we = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (idle) begin
      if (md.startE) begin
        if (is_md_op) begin
          a_d   = md.AE;
          b_d   = md.BE;
          op_d  = md.MDOPE;
          cnt_d = cnt_load;
        end else if (md.MDOPE == OP_MTHI) begin
          hi_d = md.AE;
        end else if (md.MDOPE == OP_MTLO) begin
          lo_d = md.AE;
        end
      end
    end else begin
      // Issue attempts while running are dropped; only the counter advances.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == CNT_LAST && res_we) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CNT_IDLE;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign md.busy    = !idle;
  assign md.HI      = hi_q;
  assign md.LO      = lo_q;
  assign md.stallMD = md.MDUseD && (!idle || (md.startE && is_md_op));

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: expected HI/LO queued at issue, popped by a
// monitor when busy falls; timing, stall and mthi/mtlo checked inline.
module tb_mdu_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m, lo_m;
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completing operation (busy falling outside reset) pops one entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !bus.busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected completion", 32'd1, 32'd0);
          end else begin
            res_t e;
            e = exp_q.pop_front();
            check("scoreboard HI", bus.HI, e.hi);
            check("scoreboard LO", bus.LO, e.lo);
          end
        end
        busy_prev = bus.busy;
      end
    end
  end

  task automatic idle_inputs();
    bus.startE = 1'b0;
    bus.MDOPE  = 3'd0;
    bus.AE     = 32'd0;
    bus.BE     = 32'd0;
  endtask

  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic mduse, input int exp_cyc,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic inject);
    int cyc;
    res_t e;
    if (exp_cyc > 0) begin
      e.hi = ehi;
      e.lo = elo;
      exp_q.push_back(e);
      hi_m = ehi;
      lo_m = elo;
    end
    @(posedge clk); #1;
    bus.MDOPE  = op;
    bus.AE     = a;
    bus.BE     = b;
    bus.startE = 1'b1;
    bus.MDUseD = mduse;
    #1 check({name, " stall in issue cycle"}, {31'd0, bus.stallMD}, {31'd0, mduse && (exp_cyc > 0)});
    @(posedge clk); #1;
    idle_inputs();
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      if (mduse) check({name, " stall while busy"}, {31'd0, bus.stallMD}, 32'd1);
      if (inject && cyc == 2) begin
        bus.startE = 1'b1;
        bus.MDOPE  = 3'd5;
        bus.AE     = 32'hDEAD_BEEF;
      end else begin
        idle_inputs();
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    check({name, " busy cycles"}, cyc, exp_cyc);
    if (mduse) check({name, " stall after completion"}, {31'd0, bus.stallMD}, 32'd0);
    bus.MDUseD = 1'b0;
  endtask

  task automatic mt(input string name, input logic [2:0] op, input logic [31:0] val);
    @(posedge clk); #1;
    bus.MDOPE  = op;
    bus.AE     = val;
    bus.startE = 1'b1;
    bus.MDUseD = 1'b1;
    #1 check({name, " stall in issue"}, {31'd0, bus.stallMD}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    if (op == 3'd5) hi_m = val;
    else            lo_m = val;
    check({name, " HI"}, bus.HI, hi_m);
    check({name, " LO"}, bus.LO, lo_m);
    check({name, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({name, " mflo stall"}, {31'd0, bus.stallMD}, 32'd0);
    bus.MDUseD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] abort_op;
    idle_inputs();
    bus.MDUseD = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset HI", bus.HI, 32'd0);
    check("reset LO", bus.LO, 32'd0);
    check("reset stallMD", {31'd0, bus.stallMD}, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    #19 reset_n = 1'b1;

    run_md("mult -2*3", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    run_md("multu max*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MC, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_md("mult minint^2", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, MC, 32'h4000_0000, 32'h0, 1'b0);
    run_md("mult 7*6", 3'd1, 32'd7, 32'd6, 1'b1, MC, 32'h0, 32'h2A, 1'b0);

`ifdef MDU_DIV_EN
    run_md("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, DC, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run_md("divu 100/7", 3'd4, 32'd100, 32'd7, 1'b0, DC, 32'd2, 32'd14, 1'b0);
    run_md("divu by zero", 3'd4, 32'd55, 32'd0, 1'b0, DC, hi_m, lo_m, 1'b0);
    run_md("div overflow", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 32'h0, 32'h8000_0000, 1'b0);
    abort_op = 3'd3;
`else
    run_md("div disabled", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'h0, 32'h0, 1'b0);
    check("div disabled HI", bus.HI, hi_m);
    check("div disabled LO", bus.LO, lo_m);
    run_md("divu disabled", 3'd4, 32'd100, 32'd7, 1'b0, 0, 32'h0, 32'h0, 1'b0);
    check("divu disabled LO", bus.LO, lo_m);
    abort_op = 3'd1;
`endif

    mt("mthi", 3'd5, 32'h1234_5678);
    mt("mtlo", 3'd6, 32'hCAFE_BABE);

    // Abort an operation with an asynchronous reset in its third busy cycle.
    @(posedge clk); #1;
    bus.MDOPE  = abort_op;
    bus.AE     = 32'd5;
    bus.BE     = 32'd3;
    bus.startE = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("abort busy before reset", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort HI", bus.HI, 32'd0);
    check("abort LO", bus.LO, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk); #1;
    reset_n = 1'b1;

    run_md("mult after abort", 3'd1, 32'd3, 32'd5, 1'b1, MC, 32'h0, 32'hF, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
